// File: rtl/cr_clk_pkg.sv
// rtl/cr_clk_pkg.sv - shared types and limits for the cr_clk_div_en clock-enable generator
//
// Contents:
//   cr_clk_div_state_e      per-channel gating state (RUN, DRAIN, STOP)
//   CR_CLK_CH_NUM_MIN/MAX   legal range of the channel count
//   CR_CLK_DIV_W_MIN/MAX    legal range of the divide-value width
//   cr_clk_cfg_legal()      true when a CH_NUM/DIV_W pair is in range

package cr_clk_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    STOP  = 2'b10
  } cr_clk_div_state_e;

  localparam int CR_CLK_CH_NUM_MIN = 1;
  localparam int CR_CLK_CH_NUM_MAX = 16;
  localparam int CR_CLK_DIV_W_MIN  = 1;
  localparam int CR_CLK_DIV_W_MAX  = 32;

  function automatic bit cr_clk_cfg_legal(input int ch_num, input int div_w);
    return (ch_num >= CR_CLK_CH_NUM_MIN) && (ch_num <= CR_CLK_CH_NUM_MAX) &&
           (div_w  >= CR_CLK_DIV_W_MIN)  && (div_w  <= CR_CLK_DIV_W_MAX);
  endfunction

endpackage : cr_clk_pkg

// File: rtl/cr_clk_div_ch.sv
// rtl/cr_clk_div_ch.sv - one divided-rate clock-enable channel with shadowed divide value and gating
//
// Ports:
//   forever_cpuclk  in   core clock, rising edge
//   cpurst          in   synchronous active-high reset
//   cfg_vld         in   new divide value offered
//   cfg_val         in   divide value (period = value + 1 cycles)
//   cfg_rdy         out  shadow slot is free
//   gate_req        in   level request to stop the channel
//   gate_ack        out  channel is stopped
//   en              out  registered enable pulse (test-mode OR is done by the parent)

module cr_clk_div_ch
  import cr_clk_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             cfg_vld,
  input  logic [DIV_W-1:0] cfg_val,
  output logic             cfg_rdy,
  input  logic             gate_req,
  output logic             gate_ack,
  output logic             en
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  cr_clk_div_state_e state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  act_div_q, act_div_d;
  logic [DIV_W-1:0]  shd_div_q, shd_div_d;
  logic              shd_vld_q, shd_vld_d;
  logic              en_q, en_d;
  logic              ack_q, ack_d;

  logic              cnt_zero;
  logic              cfg_acc;
  logic [DIV_W-1:0]  reload_val;

  assign cnt_zero   = (cnt_q == '0);
  assign cfg_acc    = cfg_vld & ~shd_vld_q;
  // A pending shadow wins at the reload; otherwise the period repeats.
  assign reload_val = shd_vld_q ? shd_div_q : act_div_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      act_div_q <= '0;
      shd_div_q <= '0;
      shd_vld_q <= 1'b0;
      en_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      shd_vld_q <= shd_vld_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    shd_div_d = shd_div_q;
    shd_vld_d = shd_vld_q;
    en_d      = 1'b0;
    ack_d     = ack_q;

    unique case (state_q)
      // RUN and DRAIN share one datapath: DRAIN is just RUN with the pulse
      // withheld while gate_req is high. Dropping gate_req in DRAIN takes
      // the RUN step on that same edge, so a boundary landing there still
      // pulses and the phase is untouched.
      RUN, DRAIN: begin
        if (gate_req) begin
          if (cnt_zero) begin
            // Boundary reached while gated: swallow the pulse, hold cnt at 0.
            state_d = STOP;
            ack_d   = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = RUN;
          if (cnt_zero) begin
            en_d      = 1'b1;
            cnt_d     = reload_val;
            act_div_d = reload_val;
            shd_vld_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      STOP: begin
        if (!gate_req) begin
          // Restart from a fresh boundary rather than the old phase.
          state_d = RUN;
          cnt_d   = '0;
          ack_d   = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
        ack_d   = 1'b0;
      end
    endcase

    // Evaluated after the reload so that a write on a reload edge with an
    // empty shadow lands in the shadow and waits for the following reload.
    if (cfg_acc) begin
      shd_div_d = cfg_val;
      shd_vld_d = 1'b1;
    end
  end

  assign cfg_rdy  = ~shd_vld_q;
  assign gate_ack = ack_q;
  assign en       = en_q;

endmodule : cr_clk_div_ch

// File: rtl/cr_clk_div_en.sv
// rtl/cr_clk_div_en.sv - multi-channel divided clock-enable generator with gating and scan bypass
//
// Parameters:
//   CH_NUM  number of independent channels (1..16)
//   DIV_W   divide-value width (1..32); channel period is div+1 cycles
// Ports:
//   forever_cpuclk    in   core clock, rising edge
//   cpurst            in   synchronous active-high reset
//   pad_yy_test_mode  in   forces every clk_en high for scan
//   cfg_div_vld       in   [CH_NUM]        per-channel divide value valid
//   cfg_div_val       in   [CH_NUM*DIV_W]  divide values, channel i at [i*DIV_W +: DIV_W]
//   cfg_div_rdy       out  [CH_NUM]        channel shadow free
//   gate_req          in   [CH_NUM]        level stop request
//   gate_ack          out  [CH_NUM]        channel stopped
//   clk_en            out  [CH_NUM]        one-cycle enable pulses

module cr_clk_div_en
  import cr_clk_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    pad_yy_test_mode,
  input  logic [CH_NUM-1:0]       cfg_div_vld,
  input  logic [CH_NUM*DIV_W-1:0] cfg_div_val,
  output logic [CH_NUM-1:0]       cfg_div_rdy,
  input  logic [CH_NUM-1:0]       gate_req,
  output logic [CH_NUM-1:0]       gate_ack,
  output logic [CH_NUM-1:0]       clk_en
);

  localparam bit CFG_LEGAL = cr_clk_cfg_legal(CH_NUM, DIV_W);

  logic [CH_NUM-1:0] ch_en;

  if (CFG_LEGAL) begin : g_legal
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      cr_clk_div_ch #(
        .DIV_W (DIV_W)
      ) u_ch (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .cfg_vld        (cfg_div_vld[i]),
        .cfg_val        (cfg_div_val[i*DIV_W +: DIV_W]),
        .cfg_rdy        (cfg_div_rdy[i]),
        .gate_req       (gate_req[i]),
        .gate_ack       (gate_ack[i]),
        .en             (ch_en[i])
      );
    end
  end else begin : g_illegal
    // Out-of-range parameters build an inert block rather than a wrong one.
    assign ch_en       = '0;
    assign cfg_div_rdy = '0;
    assign gate_ack    = '0;
  end

  // Scan bypass only touches the enables; gating handshake and counters
  // keep running underneath.
  assign clk_en = ch_en | {CH_NUM{pad_yy_test_mode}};

endmodule : cr_clk_div_en

// File: tb/tb_cr_clk_div_en.sv
// tb/tb_cr_clk_div_en.sv - directed self-checking bench for cr_clk_div_en

module tb_cr_clk_div_en;

  localparam int CH_NUM = 4;
  localparam int DIV_W  = 8;

  logic                    clk;
  logic                    cpurst;
  logic                    pad_yy_test_mode;
  logic [CH_NUM-1:0]       cfg_div_vld;
  logic [CH_NUM*DIV_W-1:0] cfg_div_val;
  logic [CH_NUM-1:0]       cfg_div_rdy;
  logic [CH_NUM-1:0]       gate_req;
  logic [CH_NUM-1:0]       gate_ack;
  logic [CH_NUM-1:0]       clk_en;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle patterns, bit r = value after the r-th edge of the test.
  logic [14:0] t2_en0  = 15'b010101000100011;
  logic [14:0] t2_rdy0 = 15'b111111000111110;
  logic [9:0]  t3_en1  = 10'b1001000011;
  logic [9:0]  t3_rdy1 = 10'b1111000010;
  logic [14:0] t4_en2  = 15'b010000000000011;
  logic [14:0] t4_ack2 = 15'b000111000000000;
  logic [8:0]  t5_en3  = 9'b010000011;

  cr_clk_div_en #(
    .CH_NUM (CH_NUM),
    .DIV_W  (DIV_W)
  ) dut (
    .forever_cpuclk   (clk),
    .cpurst           (cpurst),
    .pad_yy_test_mode (pad_yy_test_mode),
    .cfg_div_vld      (cfg_div_vld),
    .cfg_div_val      (cfg_div_val),
    .cfg_div_rdy      (cfg_div_rdy),
    .gate_req         (gate_req),
    .gate_ack         (gate_ack),
    .clk_en           (clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One rising edge; returns at the following falling edge where outputs
  // are stable and new inputs are applied.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_set(input int ch, input logic [DIV_W-1:0] val);
    cfg_div_vld[ch]                = 1'b1;
    cfg_div_val[ch*DIV_W +: DIV_W] = val;
  endtask

  task automatic do_reset();
    cpurst           = 1'b1;
    pad_yy_test_mode = 1'b0;
    cfg_div_vld      = '0;
    cfg_div_val      = '0;
    gate_req         = '0;
    tick();
    tick();
    cpurst = 1'b0;
  endtask

  initial begin
    cpurst           = 1'b1;
    pad_yy_test_mode = 1'b0;
    cfg_div_vld      = '0;
    cfg_div_val      = '0;
    gate_req         = '0;
    @(negedge clk);

    // Reset values and first pulses with div=0 everywhere.
    tick();
    tick();
    chk("rst_clk_en", clk_en, 4'h0);
    chk("rst_rdy", cfg_div_rdy, 4'hF);
    chk("rst_ack", gate_ack, 4'h0);
    pad_yy_test_mode = 1'b1;
    #1;
    chk("rst_clk_en_tm", clk_en, 4'hF);
    pad_yy_test_mode = 1'b0;
    #1;
    cpurst = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      tick();
      chk($sformatf("t1_clk_en_c%0d", r), clk_en, 4'hF);
      chk($sformatf("t1_rdy_c%0d", r), cfg_div_rdy, 4'hF);
      chk($sformatf("t1_ack_c%0d", r), gate_ack, 4'h0);
    end

    // Ch0: div=3 captured on a reload edge, then div=1 written mid-period.
    do_reset();
    tick();
    cfg_set(0, 8'd3);
    for (int r = 0; r <= 14; r++) begin
      if (r == 6) cfg_set(0, 8'd1);
      tick();
      if (r == 0 || r == 6) cfg_div_vld[0] = 1'b0;
      chk($sformatf("t2_en0_r%0d", r), clk_en[0], t2_en0[r]);
      chk($sformatf("t2_rdy0_r%0d", r), cfg_div_rdy[0], t2_rdy0[r]);
      chk($sformatf("t2_others_r%0d", r), clk_en[3:1], 3'b111);
    end

    // Ch1: div=4 then a second value held on vld while the shadow is full.
    do_reset();
    tick();
    cfg_set(1, 8'd4);
    for (int r = 0; r <= 9; r++) begin
      if (r == 1) cfg_set(1, 8'd2);
      tick();
      if (r == 2) cfg_div_vld[1] = 1'b0;
      chk($sformatf("t3_en1_r%0d", r), clk_en[1], t3_en1[r]);
      chk($sformatf("t3_rdy1_r%0d", r), cfg_div_rdy[1], t3_rdy1[r]);
    end

    // Ch2: div=7, gate at cnt=5, scan bypass while stopped, then ungate.
    do_reset();
    tick();
    cfg_set(2, 8'd7);
    for (int r = 0; r <= 14; r++) begin
      if (r == 4)  gate_req[2] = 1'b1;
      if (r == 12) gate_req[2] = 1'b0;
      tick();
      if (r == 0) cfg_div_vld[2] = 1'b0;
      chk($sformatf("t4_en2_r%0d", r), clk_en[2], t4_en2[r]);
      chk($sformatf("t4_ack2_r%0d", r), gate_ack[2], t4_ack2[r]);
      if (r == 10) begin
        pad_yy_test_mode = 1'b1;
        #1;
        chk("t4_tm_clk_en", clk_en, 4'hF);
        chk("t4_tm_ack", gate_ack, 4'b0100);
        pad_yy_test_mode = 1'b0;
        #1;
      end
    end

    // Ch3: div=5, two-cycle gate blip in DRAIN, then reset mid-DRAIN with a
    // pending shadow on ch0.
    do_reset();
    tick();
    cfg_set(3, 8'd5);
    for (int r = 0; r <= 8; r++) begin
      if (r == 2) gate_req[3] = 1'b1;
      if (r == 4) gate_req[3] = 1'b0;
      if (r == 8) begin
        gate_req[3] = 1'b1;
        cfg_set(0, 8'd9);
      end
      tick();
      if (r == 0) cfg_div_vld[3] = 1'b0;
      chk($sformatf("t5_en3_r%0d", r), clk_en[3], t5_en3[r]);
      chk($sformatf("t5_ack3_r%0d", r), gate_ack[3], 1'b0);
    end
    chk("t5_rdy0_pending", cfg_div_rdy[0], 1'b0);
    cpurst = 1'b1;
    tick();
    chk("t6_rst_clk_en", clk_en, 4'h0);
    chk("t6_rst_rdy", cfg_div_rdy, 4'hF);
    chk("t6_rst_ack", gate_ack, 4'h0);
    cpurst      = 1'b0;
    cfg_div_vld = '0;
    gate_req    = '0;
    tick();
    chk("t6_post_c1", clk_en, 4'hF);
    tick();
    chk("t6_post_c2", clk_en, 4'hF);
    chk("t6_post_rdy", cfg_div_rdy, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cr_clk_div_en

// File: doc/cr_clk_div_en.md
# cr_clk_div_en

Multi-channel clock-enable generator in the clock domain of the core. It derives `CH_NUM` independent divided-rate enable pulses from `forever_cpuclk`, each with its own runtime-programmable divide ratio and request/acknowledge gating for low-power shutdown. `pad_yy_test_mode` bypasses the dividers so that every enable is forced on for scan. Downstream units feed `clk_en[i]` into their clock-gating cells or register enables.

## Interface
- `CH_NUM`, default 4: number of independent channels, range 1..16.
- `DIV_W`, default 8: divide-value width. Channel period is `div+1` cycles.
- `forever_cpuclk  in  1`: sole clock; all state updates on its rising edge.
- `cpurst  in  1`: reset, synchronous, active-high.
- `pad_yy_test_mode  in  1`: scan/test bypass.
- `cfg_div_vld  in  CH_NUM`: per-channel new-divide-value valid.
- `cfg_div_val  in  CH_NUM*DIV_W`: divide values. Channel i uses bits `[i*DIV_W +: DIV_W]`.
- `cfg_div_rdy  out  CH_NUM`: the channel can accept a new divide value.
- `gate_req  in  CH_NUM`: level request to stop the channel.
- `gate_ack  out  CH_NUM`: the channel is stopped.
- `clk_en  out  CH_NUM`: enable pulse, one cycle wide.

## Operation
Each channel holds the following registers:
- `cnt` (DIV_W bits), a down-counter.
- `act_div`, the divide value in use.
- `shd_div` plus `shd_vld`, a one-entry shadow for a pending value.
- `state` in {RUN, DRAIN, STOP}.
- `en_q` and `ack_q`.

Reset values (at the edge where `cpurst` is high): `cnt=0`, `act_div=0`, `shd_vld=0`, `state=RUN`, `en_q=0`, `ack_q=0`. Port values after reset:
- `cfg_div_rdy=1`.
- `gate_ack=0`.
- `clk_en` equals `pad_yy_test_mode` (0 in functional mode).

State behaviour:
- **RUN**
  - If `cnt==0`: set `en_q<=1` and reload. The reload value is `shd_div` if `shd_vld`, otherwise `act_div`. Set `act_div<=` the reload value and clear `shd_vld`.
  - If `cnt!=0`: `en_q<=0`, `cnt<=cnt-1`.
  - If `gate_req` is high and `cnt!=0`: go to DRAIN.
  - If `gate_req` is high and `cnt==0`: go to STOP, `en_q<=0` (the pulse is suppressed), no reload, `ack_q<=1`.
- **DRAIN**
  - Counts down with `en_q=0`.
  - If `gate_req` falls: return to RUN and keep counting. No pulse is lost; the next pulse still comes at `cnt==0`.
  - When `cnt==0` with `gate_req` still high: go to STOP, `ack_q<=1`.
- **STOP**
  - `en_q=0`, `cnt` is held.
  - On `gate_req` low: go to RUN, `cnt<=0`, `ack_q<=0`.

Configuration handshake:
- `cfg_div_rdy = ~shd_vld`.
- On `vld&rdy`: `shd_div<=val`, `shd_vld<=1`.
- The shadow is applied only at the next reload, so a period in progress is never truncated.
- Config writes are accepted in every state, including STOP.
- If `vld&rdy` lands on the same edge as a reload with `shd_vld=0`, the value is captured into the shadow only. It takes effect at the following reload.

Outputs:
- `clk_en = en_q | {CH_NUM{pad_yy_test_mode}}`. This is the only combinational path.
- `gate_ack = ack_q`, unaffected by test mode.
- Internal state keeps advancing in test mode.

## Timing
- First pulse: `clk_en=1` in the cycle after the first edge with `cpurst` low.
- With `div=0`, `clk_en` is continuously 1. With `div=d`, it pulses once every `d+1` cycles.
- New value: the pulse at the current boundary still uses the old period. The following interval uses `d_new+1`.
- Gate entry latency: `gate_ack` rises at the edge where `cnt` reaches 0, at most `act_div+1` cycles after `gate_req`. There is no pulse in that cycle.
- Gate exit:
  - `gate_ack` falls 1 edge after `gate_req` falls.
  - The first pulse follows on the next edge (2 edges total).
  - The phase is reset: the channel realigns and does not resume its old phase.
- Reset mid-operation: all of the above is abandoned on the next edge, and any pending shadow is discarded.
- Channels are fully independent; there is no cross-channel phase alignment.

## Structure
- Package `cr_clk_pkg` holds:
  - the state enum `cr_clk_div_state_e` (RUN=2'b00, DRAIN=2'b01, STOP=2'b10);
  - the constants for the `CH_NUM` and `DIV_W` limits.
- Sub-module `cr_clk_div_ch` implements one channel (all registers above, parameter `DIV_W`).
- The top level instantiates `CH_NUM` copies in a generate loop, slices `cfg_div_val`, and ORs in test mode.

## Test plan
- Reset, then `div=0` on all channels → `clk_en=4'hF` every cycle from cycle 1. `cfg_div_rdy=4'hF`, `gate_ack=0`.
- Ch0 `div=3` → pulses at cycles 1, 5, 9, …. Writing `div=1` at cycle 6 gives the pulse at 9 on the old period, then pulses at 11, 13.
- Ch1 `div=4`, with a second config pushed before the reload → `rdy` is low until the reload edge, and the second `vld` is held off.
- Ch2 `div=7`, `gate_req` raised at cnt=5 → no further pulse, `gate_ack` rises 6 edges later. Dropping `gate_req` gives `ack` low after 1 edge and a pulse after 2.
- Ch3 `gate_req` pulsed high for 2 cycles in DRAIN → returns to RUN, pulse timing is unchanged, and `gate_ack` never rises.
- `pad_yy_test_mode=1` while ch2 is STOP → `clk_en=4'hF`, `gate_ack[2]` stays 1. Asserting `cpurst` mid-DRAIN → all registers return to their reset values on the next edge.
